div_share_ctrl: RTL and testbench

Round-robin scheduler that shares one sequential 22-bit/12-bit integer divider (22-cycle iterative, startp/busy interface) among NCH requesters. It captures one requester's dividend/divisor and pulses the divider start, waits for completion, then returns quotient and remainder with a per-channel done pulse. Divide-by-zero is trapped without starting the divider. It sits between the channel clients and the single divider instance.

---
 rtl/div_share_if.sv | 22 ++
 rtl/div_share_ctrl.sv | 127 ++++++++++++
 tb/tb_div_share_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_share_if.sv
// Requester-side bundle of div_share_ctrl.
//   req/req_z/req_d : per-channel request level and operands (client -> ctrl)
//   ack/done        : per-channel one-cycle pulses (ctrl -> client)
//   q/r/dz          : shared result bus, valid while a done bit is high
//   busy            : controller is not idle
// slave is the controller's view; master is the clients' view.
interface div_share_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0]    req;
    logic [NCH*22-1:0] req_z;
    logic [NCH*12-1:0] req_d;
    logic [NCH-1:0]    ack;
    logic [NCH-1:0]    done;
    logic [21:0]       q;
    logic [11:0]       r;
    logic              dz;
    logic              busy;

    modport slave  (input  req, req_z, req_d, output ack, done, q, r, dz, busy);
    modport master (output req, req_z, req_d, input  ack, done, q, r, dz, busy);
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin arbiter sharing one 22/12-bit iterative divider among NCH
// requesters. A grant captures the winner's operands into div_z/div_d,
// pulses div_startp, waits for div_busy to fall and returns q/r with a
// done pulse on the winner's channel. A zero divisor is answered directly
// (q all ones, r 0, dz 1) without touching the divider.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ch (slave)          : requester bundle (req/req_z/req_d/ack/done/q/r/dz/busy)
//   div_z, div_d        : registered operands to the divider
//   div_startp          : one-cycle divider start
//   div_q, div_r        : divider results
//   div_busy            : divider computing
module div_share_ctrl #(
    parameter int NCH = 4
) (
    input  logic        clk,
    input  logic        rst,
    div_share_if.slave  ch,
    output logic [21:0] div_z,
    output logic [11:0] div_d,
    output logic        div_startp,
    input  logic [21:0] div_q,
    input  logic [11:0] div_r,
    input  logic        div_busy
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        logic [21:0] q;
        logic [11:0] r;
        logic        dz;
    } res_t;

    state_t          state, state_nx;
    logic [PW-1:0]   ptr;     // last granted channel
    logic [PW-1:0]   act;     // channel being served
    res_t            res;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic [21:0]     gnt_z;
    logic [11:0]     gnt_d;

    logic [NCH-1:0]  ack_c, done_c;
    logic            startp_c, busy_c;

    // Search ptr+1, ptr+2, ... with wraparound; first requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_found && ch.req[(int'(ptr) + i) % NCH]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'((int'(ptr) + i) % NCH);
            end
        end
    end

    assign gnt_z = ch.req_z[int'(gnt_idx)*22 +: 22];
    assign gnt_d = ch.req_d[int'(gnt_idx)*12 +: 12];

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ack_c    = '0;
        done_c   = '0;
        startp_c = 1'b0;
        busy_c   = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (gnt_found) begin
                    ack_c    = NCH'(1) << gnt_idx;
                    state_nx = (gnt_d == '0) ? S_DONE : S_START;
                end
            end
            S_START: begin
                startp_c = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (!div_busy) state_nx = S_DONE;
            end
            S_DONE: begin
                done_c   = NCH'(1) << act;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Pulses are suppressed while rst is high so an aborted operation never
    // reports done and no grant is taken during reset.
    assign ch.ack     = rst ? '0 : ack_c;
    assign ch.done    = rst ? '0 : done_c;
    assign div_startp = rst ? 1'b0 : startp_c;
    assign ch.busy    = rst ? 1'b0 : busy_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= PW'(NCH - 1);
            act   <= '0;
            div_z <= '0;
            div_d <= '0;
            res   <= '0;
        end else begin
            if (state == S_IDLE && gnt_found) begin
                ptr   <= gnt_idx;
                act   <= gnt_idx;
                div_z <= gnt_z;
                div_d <= gnt_d;
                if (gnt_d == '0) res <= '{q: 22'h3FFFFF, r: 12'h000, dz: 1'b1};
            end
            if (state == S_WAIT && !div_busy)
                res <= '{q: div_q, r: div_r, dz: 1'b0};
        end
    end

    assign ch.q  = res.q;
    assign ch.r  = res.r;
    assign ch.dz = res.dz;
endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_share_if #(.NCH(NCH)) bus();
    logic [21:0] div_z, div_q;
    logic [11:0] div_d, div_r;
    logic        div_startp, div_busy;

    div_share_ctrl #(.NCH(NCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ch         (bus),
        .div_z      (div_z),
        .div_d      (div_d),
        .div_startp (div_startp),
        .div_q      (div_q),
        .div_r      (div_r),
        .div_busy   (div_busy)
    );

    // Divider model: busy for 22 cycles starting the cycle after startp.
    int m_cnt;
    always @(posedge clk) begin
        if (rst) begin
            div_busy <= 1'b0; m_cnt <= 0; div_q <= '0; div_r <= '0;
        end else if (div_startp) begin
            m_cnt    <= 22;
            div_busy <= 1'b1;
            if (div_d != 0) begin
                div_q <= div_z / 22'(div_d);
                div_r <= 12'(div_z % 22'(div_d));
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) div_busy <= 1'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int st_cnt = 0, st_cyc = -1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (div_startp) begin st_cnt++; st_cyc = cyc; end
        if (!rst) begin
            chk("ack_done_exclusive", longint'((bus.ack != 0) && (bus.done != 0)), 0);
            chk("done_onehot", longint'($countones(bus.done) > 1), 0);
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic reset_chk(input string nm);
        chk({nm, " ack"}, bus.ack, 0);
        chk({nm, " done"}, bus.done, 0);
        chk({nm, " q"}, bus.q, 0);
        chk({nm, " r"}, bus.r, 0);
        chk({nm, " dz"}, bus.dz, 0);
        chk({nm, " busy"}, bus.busy, 0);
        chk({nm, " startp"}, div_startp, 0);
        chk({nm, " div_z"}, div_z, 0);
        chk({nm, " div_d"}, div_d, 0);
    endtask

    // Single operation on one channel; checks grant, start, latency, result.
    task automatic do_op(input string nm, input int c, input logic [21:0] z,
                         input logic [11:0] d, input logic [21:0] eq,
                         input logic [11:0] er, input logic edz);
        int a, s0;
        bus.req_z[c*22 +: 22] = z;
        bus.req_d[c*12 +: 12] = d;
        bus.req[c] = 1'b1;
        #1;
        for (int t = 0; t < 10; t++) begin
            if (bus.ack != 0) break;
            step();
        end
        chk({nm, " ack"}, bus.ack, longint'(1) << c);
        chk({nm, " busy_at_ack"}, bus.busy, 0);
        a  = cyc;
        s0 = st_cnt;
        @(posedge clk); #1;
        bus.req[c] = 1'b0;
        for (int t = 0; t < 40; t++) begin
            step();
            if (bus.done != 0) break;
        end
        chk({nm, " done"}, bus.done, longint'(1) << c);
        chk({nm, " latency"}, cyc - a, edz ? 1 : 25);
        chk({nm, " q"}, bus.q, eq);
        chk({nm, " r"}, bus.r, er);
        chk({nm, " dz"}, bus.dz, edz);
        chk({nm, " busy_at_done"}, bus.busy, 1);
        chk({nm, " startp_count"}, st_cnt - s0, edz ? 0 : 1);
        if (!edz) chk({nm, " startp_cycle"}, st_cyc, a + 1);
        step();
        chk({nm, " idle_after"}, bus.busy, 0);
    endtask

    logic [21:0] mz [4], mq [4];
    logic [11:0] md [4], mr [4];

    // Several channels requesting at once; ord holds expected grant order
    // as nibbles, lowest first. Acks must be spaced 26 cycles apart.
    task automatic multi(input string nm, input logic [3:0] mask, input int n,
                         input logic [15:0] ord);
        int na, nd, t0;
        int gnt [4];
        bit drop;
        for (int k = 0; k < NCH; k++) begin
            bus.req_z[k*22 +: 22] = mz[k];
            bus.req_d[k*12 +: 12] = md[k];
        end
        bus.req = mask;
        #1;
        na = 0; nd = 0; drop = 1'b0; t0 = cyc;
        for (int t = 0; t < n*26 + 20 && nd < n; t++) begin
            if (bus.ack != 0) begin
                if (na < n) begin
                    gnt[na] = int'(ord[4*na +: 4]);
                    chk({nm, " grant"}, bus.ack, longint'(1) << gnt[na]);
                    chk({nm, " ack_cycle"}, cyc - t0, 26*na);
                    na++;
                    if (na == n) drop = 1'b1;
                end else begin
                    chk({nm, " extra_grant"}, bus.ack, 0);
                end
            end
            if (bus.done != 0 && nd < na) begin
                chk({nm, " done_ch"}, bus.done, longint'(1) << gnt[nd]);
                chk({nm, " q"}, bus.q, mq[gnt[nd]]);
                chk({nm, " r"}, bus.r, mr[gnt[nd]]);
                nd++;
            end
            @(posedge clk); #1;
            if (drop) bus.req = '0;
            @(negedge clk); #1;
        end
        chk({nm, " grants_seen"}, na, n);
        chk({nm, " dones_seen"}, nd, n);
        bus.req = '0;
    endtask

    typedef struct {
        int          c;
        logic [21:0] z;
        logic [11:0] d;
        logic [21:0] q;
        logic [11:0] r;
        logic        dz;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, a;
        vt[0] = '{0, 22'd1000,    12'd7,     22'd142,     12'd6,    1'b0};
        vt[1] = '{2, 22'h3FFFFF,  12'hFFF,   22'd1024,    12'd1023, 1'b0};
        vt[2] = '{1, 22'd5,       12'd0,     22'h3FFFFF,  12'd0,    1'b1};
        vt[3] = '{3, 22'd0,       12'd1,     22'd0,       12'd0,    1'b0};
        vt[4] = '{1, 22'd5,       12'd9,     22'd0,       12'd5,    1'b0};
        vt[5] = '{0, 22'h3FFFFF,  12'd1,     22'h3FFFFF,  12'd0,    1'b0};
        vt[6] = '{3, 22'd77,      12'd77,    22'd1,       12'd0,    1'b0};
        vt[7] = '{2, 22'd0,       12'd0,     22'h3FFFFF,  12'd0,    1'b1};
        mz = '{22'd1000, 22'd50000, 22'h3FFFFF, 22'd12345};
        md = '{12'd7,    12'd123,   12'hFFF,    12'd100};
        mq = '{22'd142,  22'd406,   22'd1024,   22'd123};
        mr = '{12'd6,    12'd62,    12'd1023,   12'd45};

        bus.req = '0; bus.req_z = '0; bus.req_d = '0;
        rst = 1'b1;
        repeat (3) step();
        reset_chk("reset");
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vt[i].c, vt[i].z, vt[i].d,
                  vt[i].q, vt[i].r, vt[i].dz);

        // ptr=2 after this, so ch3 must beat ch1.
        do_op("rr_pre", 2, mz[2], md[2], mq[2], mr[2], 1'b0);
        multi("rr1010", 4'b1010, 2, 16'h0013);
        step();

        // Reset during WAIT: no done for the aborted operation.
        bus.req_z[0 +: 22] = 22'd1000;
        bus.req_d[0 +: 12] = 12'd7;
        bus.req[0] = 1'b1;
        #1;
        chk("abort ack", bus.ack, 1);
        a = cyc;
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        for (int t = 0; t < 20 && cyc < a + 10; t++) step();
        chk("abort busy_in_wait", bus.busy, 1);
        rst = 1'b1;
        step();
        reset_chk("abort_rst");
        rst = 1'b0;
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            step();
            if (bus.done != 0) ndone++;
        end
        chk("abort no_done", ndone, 0);
        do_op("post_reset", 0, 22'd1000, 12'd7, 22'd142, 12'd6, 1'b0);

        // All four held from reset: ptr must come out of reset at NCH-1.
        rst = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            bus.req_z[k*22 +: 22] = mz[k];
            bus.req_d[k*12 +: 12] = md[k];
        end
        bus.req = 4'b1111;
        step();
        step();
        reset_chk("rst_req_held");
        rst = 1'b0;
        multi("rr1111", 4'b1111, 4, 16'h3210);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
